multi_sample_voter: RTL and testbench
=====================================

MULTI_SAMPLE_VOTER -- requirements
Module: multi_sample_voter

Interface
REQ-001 SHALL have parameter EDGE_W, default 6, meaning width of EDGE_CNT and PRESCALE.
REQ-002 SHALL have port CLK  input  1  the single clock; all logic is rising-edge.
REQ-003 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-004 SHALL have port RX_IN  input  1  serial line, already synchronised.
REQ-005 SHALL have port DAT_SAMP_EN  input  1  sampling enable for the current bit period.
REQ-006 SHALL have port EDGE_CNT  input  EDGE_W  oversample index within the bit; 0..PRESCALE-1, +1 per CLK while enabled.
REQ-007 SHALL have port PRESCALE  input  EDGE_W  oversampling ratio, even, static while enabled.
REQ-008 SHALL have port SAMP_MODE  input  2  vote depth: 00 = 1 sample, 01 = 3 samples, 10 = 5 samples, 11 = 3 samples.
REQ-009 SHALL have port SAMPLED_BIT  output  1  voted bit value.
REQ-010 SHALL have port SAMPLE_VLD  output  1  one-CLK strobe; SAMPLED_BIT/NOISE_FLAG are new.
REQ-011 SHALL have port NOISE_FLAG  output  1  samples of the last vote were not unanimous.
REQ-012 SHALL have port CFG_ERR  output  1  PRESCALE too small for the latched mode.

Function
REQ-013 SHALL latch SAMP_MODE into the active mode on any CLK edge where DAT_SAMP_EN=1 and EDGE_CNT=0; SAMP_MODE changes mid-bit SHALL have no effect until the next EDGE_CNT=0.
REQ-014 SHALL define N = 1, 3 or 5 from the active mode, K = (N-1)/2, C = PRESCALE>>1; arithmetic SHALL be EDGE_W+1 bits wide, with no wrap.
REQ-015 SHALL assert CFG_ERR (registered) while PRESCALE < 2K+2; while CFG_ERR=1 the block SHALL vote with N=1, K=0.
REQ-016 SHALL, on each CLK edge with DAT_SAMP_EN=1 and C-K <= EDGE_CNT <= C+K, add RX_IN to a ones counter and increment a sample counter (3 bits each).
REQ-017 SHALL, on the edge where EDGE_CNT = C+K with DAT_SAMP_EN=1, register SAMPLED_BIT = (ones including the current RX_IN) > K, and NOISE_FLAG = ones neither 0 nor N.
REQ-018 SHALL, on that same edge, set SAMPLE_VLD to 1 for exactly one CLK; the result SHALL be visible one cycle after the last sample.
REQ-019 SHALL clear the ones and sample counters on the edge after a vote completes and on any edge with EDGE_CNT=0.
REQ-020 SHALL hold SAMPLED_BIT and NOISE_FLAG between votes; they SHALL NOT be cleared by DAT_SAMP_EN=0.
REQ-021 SHALL, when DAT_SAMP_EN=0, clear the counters and keep SAMPLE_VLD=0; a window interrupted by deassertion SHALL produce no SAMPLE_VLD.
REQ-022 SHALL produce no SAMPLE_VLD if the sample counter does not equal N at EDGE_CNT = C+K (partial window after late enable); the counters SHALL be cleared instead.
REQ-023 SHALL produce at most one SAMPLE_VLD per bit period, with EDGE_CNT 0 to PRESCALE-1.
REQ-024 SHALL use RX_IN only inside the window; values outside it SHALL be ignored.

Reset
REQ-025 SHALL, on RST=1 at a CLK edge, set SAMPLED_BIT=0, SAMPLE_VLD=0, NOISE_FLAG=0, CFG_ERR=0, counters=0 and active mode=3-sample; RST SHALL override all other inputs.
REQ-026 SHALL, when reset is asserted mid-window, discard the partial window, and the first vote SHALL follow the next EDGE_CNT=0.

Verification
REQ-027 SHALL be verified for PRESCALE=8, mode 10, RX_IN at EDGE_CNT 2..6 = 1,1,0,1,1 -> SAMPLED_BIT=1, NOISE_FLAG=1, SAMPLE_VLD pulse in the cycle after EDGE_CNT=6.
REQ-028 SHALL be verified for PRESCALE=16, mode 01, RX_IN at EDGE_CNT 7,8,9 = 0,1,0 -> SAMPLED_BIT=0, NOISE_FLAG=1; then all 1 -> SAMPLED_BIT=1, NOISE_FLAG=0.
REQ-029 SHALL be verified for PRESCALE=4, mode 10 -> CFG_ERR=1 and a single-sample vote at EDGE_CNT=2; for PRESCALE=6 -> CFG_ERR=0 and window 1..5.
REQ-030 SHALL be verified for DAT_SAMP_EN dropped at EDGE_CNT=5 (PRESCALE=8, mode 10) -> no SAMPLE_VLD, and SAMPLED_BIT holds its previous value.
REQ-031 SHALL be verified for SAMP_MODE changed 10 to 00 at EDGE_CNT=3 -> the current bit still votes over 5 samples, and the next bit samples only EDGE_CNT=4.
REQ-032 SHALL be verified for RST pulsed at EDGE_CNT=4 -> all outputs 0 next cycle, and no SAMPLE_VLD until after the following EDGE_CNT=0 window completes.

Source files
------------

// File: rtl/multi_sample_voter.sv
// Purpose : majority vote of 1/3/5 oversamples centred on the middle of each serial bit period.
// Latency : SAMPLED_BIT/NOISE_FLAG/SAMPLE_VLD are registered one CLK after the last sample in the window.
// Backpr. : none; the voter follows EDGE_CNT/DAT_SAMP_EN and cannot stall the sampler.
//
// Ports:
//   CLK, RST     rising-edge clock, synchronous active-high reset
//   RX_IN        synchronised serial line
//   DAT_SAMP_EN  sampling enable for the current bit period
//   EDGE_CNT     oversample index within the bit (0..PRESCALE-1)
//   PRESCALE     oversampling ratio (even, static while enabled)
//   SAMP_MODE    vote depth: 00=1, 01=3, 10=5, 11=3 samples
//   SAMPLED_BIT  voted bit, held between votes
//   SAMPLE_VLD   one-CLK strobe when a vote completes
//   NOISE_FLAG   samples of the last vote were not unanimous
//   CFG_ERR      PRESCALE too small for the latched mode (vote falls back to 1 sample)
module multi_sample_voter #(
  parameter int EDGE_W = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_IN,
  input  logic              DAT_SAMP_EN,
  input  logic [EDGE_W-1:0] EDGE_CNT,
  input  logic [EDGE_W-1:0] PRESCALE,
  input  logic [1:0]        SAMP_MODE,
  output logic              SAMPLED_BIT,
  output logic              SAMPLE_VLD,
  output logic              NOISE_FLAG,
  output logic              CFG_ERR
);

  localparam int W1 = EDGE_W + 1;

  logic [1:0]    mode_q;
  logic [2:0]    ones_q;
  logic [2:0]    cnt_q;

  logic          bit_start;
  logic [1:0]    eff_mode;
  logic [2:0]    n_mode;
  logic [1:0]    k_mode;
  logic          cfg_err_c;
  logic [2:0]    n_eff;
  logic [1:0]    k_eff;
  logic [W1-1:0] ctr;
  logic [W1-1:0] win_lo;
  logic [W1-1:0] win_hi;
  logic [W1-1:0] edge_x;
  logic          in_win;
  logic          is_last;
  logic [2:0]    ones_tot;
  logic [2:0]    cnt_tot;
  logic          vote_bit;
  logic          vote_noise;

  // The mode register only loads at EDGE_CNT=0, so on that very edge the
  // incoming SAMP_MODE is already the mode governing this bit.
  assign bit_start = DAT_SAMP_EN && (EDGE_CNT == '0);
  assign eff_mode  = bit_start ? SAMP_MODE : mode_q;

  always_comb begin
    n_mode = 3'd3;
    k_mode = 2'd1;
    case (eff_mode)
      2'b00:   begin n_mode = 3'd1; k_mode = 2'd0; end
      2'b10:   begin n_mode = 3'd5; k_mode = 2'd2; end
      default: begin n_mode = 3'd3; k_mode = 2'd1; end
    endcase
  end

  // The window C-K..C+K must fit inside 1..PRESCALE-1; otherwise fall back
  // to a single centre sample so the window never reaches below zero.
  assign cfg_err_c = ({1'b0, PRESCALE} < (W1'({k_mode, 1'b0}) + W1'(2)));
  assign n_eff     = cfg_err_c ? 3'd1 : n_mode;
  assign k_eff     = cfg_err_c ? 2'd0 : k_mode;

  assign ctr     = {1'b0, PRESCALE} >> 1;
  assign win_lo  = ctr - W1'(k_eff);
  assign win_hi  = ctr + W1'(k_eff);
  assign edge_x  = {1'b0, EDGE_CNT};
  assign in_win  = (edge_x >= win_lo) && (edge_x <= win_hi);
  assign is_last = (edge_x == win_hi);

  // Totals include the sample arriving on the current edge.
  assign ones_tot   = ones_q + {2'b00, RX_IN};
  assign cnt_tot    = cnt_q + 3'd1;
  assign vote_bit   = (ones_tot > {1'b0, k_eff});
  assign vote_noise = (ones_tot != 3'd0) && (ones_tot != n_eff);

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q      <= 2'b01;
      ones_q      <= '0;
      cnt_q       <= '0;
      SAMPLED_BIT <= 1'b0;
      SAMPLE_VLD  <= 1'b0;
      NOISE_FLAG  <= 1'b0;
      CFG_ERR     <= 1'b0;
    end else begin
      SAMPLE_VLD <= 1'b0;
      CFG_ERR    <= cfg_err_c;
      if (bit_start) begin
        mode_q <= SAMP_MODE;
      end
      if (!DAT_SAMP_EN) begin
        ones_q <= '0;
        cnt_q  <= '0;
      end else if (in_win && is_last) begin
        // A window entered late (enable or reset mid-bit) is short of
        // samples; drop it rather than vote on partial data.
        if (cnt_tot == n_eff) begin
          SAMPLED_BIT <= vote_bit;
          NOISE_FLAG  <= vote_noise;
          SAMPLE_VLD  <= 1'b1;
        end
        ones_q <= '0;
        cnt_q  <= '0;
      end else if (in_win) begin
        ones_q <= ones_tot;
        cnt_q  <= cnt_tot;
      end else begin
        // Outside the window (including EDGE_CNT=0) the counters stay
        // empty, so RX_IN there can never leak into a vote.
        ones_q <= '0;
        cnt_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_multi_sample_voter.sv
// Purpose : directed-vector check of multi_sample_voter against hand-computed results.
// Latency : inputs driven on the falling edge, outputs observed on the following falling edge.
// Backpr. : not applicable.
module tb_multi_sample_voter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       DAT_SAMP_EN;
  logic [5:0] EDGE_CNT;
  logic [5:0] PRESCALE;
  logic [1:0] SAMP_MODE;
  logic       SAMPLED_BIT;
  logic       SAMPLE_VLD;
  logic       NOISE_FLAG;
  logic       CFG_ERR;

  int n_vec = 0;
  int n_err = 0;

  // Results captured by run_bit.
  int         vld_cnt;
  int         vld_edge;
  logic       got_bit;
  logic       got_noise;
  logic [3:0] post_rst;
  logic       rst_seen;

  multi_sample_voter #(.EDGE_W(6)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .DAT_SAMP_EN (DAT_SAMP_EN),
    .EDGE_CNT    (EDGE_CNT),
    .PRESCALE    (PRESCALE),
    .SAMP_MODE   (SAMP_MODE),
    .SAMPLED_BIT (SAMPLED_BIT),
    .SAMPLE_VLD  (SAMPLE_VLD),
    .NOISE_FLAG  (NOISE_FLAG),
    .CFG_ERR     (CFG_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one bit period EDGE_CNT=0..p-1 followed by one idle cycle.
  // rx[e] is the line value at EDGE_CNT=e. drop_at/rst_at/chg_at < 0 disable
  // the enable drop, the reset pulse and the mid-bit mode change.
  task automatic run_bit(input int p, input logic [1:0] m, input logic [15:0] rx,
                         input int drop_at, input int rst_at,
                         input int chg_at, input logic [1:0] m2);
    vld_cnt  = 0;
    vld_edge = -1;
    rst_seen = 1'b0;
    PRESCALE = 6'(p);
    for (int e = 0; e <= p; e++) begin
      @(negedge CLK);
      if (SAMPLE_VLD) begin
        vld_cnt++;
        vld_edge  = e - 1;
        got_bit   = SAMPLED_BIT;
        got_noise = NOISE_FLAG;
      end
      if (RST) begin
        post_rst = {SAMPLED_BIT, SAMPLE_VLD, NOISE_FLAG, CFG_ERR};
        rst_seen = 1'b1;
      end
      RST = (e == rst_at);
      if (e < p) begin
        EDGE_CNT    = 6'(e);
        RX_IN       = rx[e];
        DAT_SAMP_EN = (drop_at < 0) || (e < drop_at);
        SAMP_MODE   = (chg_at >= 0 && e >= chg_at) ? m2 : m;
      end else begin
        EDGE_CNT    = '0;
        RX_IN       = 1'b0;
        DAT_SAMP_EN = 1'b0;
      end
    end
  endtask

  initial begin
    RST = 1'b1; RX_IN = 1'b0; DAT_SAMP_EN = 1'b0;
    EDGE_CNT = '0; PRESCALE = 6'd8; SAMP_MODE = 2'b01;
    repeat (2) @(negedge CLK);
    chk("rst_bit",   SAMPLED_BIT, 0);
    chk("rst_vld",   SAMPLE_VLD,  0);
    chk("rst_noise", NOISE_FLAG,  0);
    chk("rst_cfg",   CFG_ERR,     0);
    RST = 1'b0;

    // P=8, 5 samples at 2..6 = 1,1,0,1,1; zeros outside the window.
    run_bit(8, 2'b10, 16'h006C, -1, -1, -1, 2'b00);
    chk("p8m10_cnt",   vld_cnt,   1);
    chk("p8m10_edge",  vld_edge,  6);
    chk("p8m10_bit",   got_bit,   1);
    chk("p8m10_noise", got_noise, 1);
    chk("p8m10_cfg",   CFG_ERR,   0);

    // P=16, 3 samples at 7..9 = 0,1,0; ones outside must be ignored.
    run_bit(16, 2'b01, 16'hFD7F, -1, -1, -1, 2'b00);
    chk("p16a_cnt",   vld_cnt,   1);
    chk("p16a_edge",  vld_edge,  9);
    chk("p16a_bit",   got_bit,   0);
    chk("p16a_noise", got_noise, 1);
    run_bit(16, 2'b01, 16'h0380, -1, -1, -1, 2'b00);
    chk("p16b_bit",   got_bit,   1);
    chk("p16b_noise", got_noise, 0);

    // P=4 is too small for 5 samples: single sample at EDGE_CNT=2.
    run_bit(4, 2'b10, 16'h0004, -1, -1, -1, 2'b00);
    chk("p4_cfg",   CFG_ERR,   1);
    chk("p4_cnt",   vld_cnt,   1);
    chk("p4_edge",  vld_edge,  2);
    chk("p4_bit",   got_bit,   1);
    chk("p4_noise", got_noise, 0);
    run_bit(4, 2'b10, 16'h000B, -1, -1, -1, 2'b00);
    chk("p4b_bit",   got_bit,   0);
    chk("p4b_noise", got_noise, 0);

    // P=6 fits exactly: window 1..5 = 1,0,1,0,1 -> 3 of 5.
    run_bit(6, 2'b10, 16'h002A, -1, -1, -1, 2'b00);
    chk("p6_cfg",   CFG_ERR,   0);
    chk("p6_edge",  vld_edge,  5);
    chk("p6_bit",   got_bit,   1);
    chk("p6_noise", got_noise, 1);

    // Enable dropped at EDGE_CNT=5: no vote, outputs hold.
    run_bit(8, 2'b10, 16'h0000, 5, -1, -1, 2'b00);
    chk("drop_cnt",   vld_cnt,     0);
    chk("drop_bit",   SAMPLED_BIT, 1);
    chk("drop_noise", NOISE_FLAG,  1);

    // Mode 10 -> 00 at EDGE_CNT=3: this bit still votes 5 (0,0,1,1,1).
    run_bit(8, 2'b10, 16'h0070, -1, -1, 3, 2'b00);
    chk("mchg_cnt",   vld_cnt,   1);
    chk("mchg_edge",  vld_edge,  6);
    chk("mchg_bit",   got_bit,   1);
    chk("mchg_noise", got_noise, 1);
    // Next bit in mode 00 samples only EDGE_CNT=4.
    run_bit(8, 2'b00, 16'hFFEF, -1, -1, -1, 2'b00);
    chk("m00_cnt",   vld_cnt,   1);
    chk("m00_edge",  vld_edge,  4);
    chk("m00_bit",   got_bit,   0);
    chk("m00_noise", got_noise, 0);

    // Set outputs non-zero, then reset at EDGE_CNT=4 mid-window.
    run_bit(8, 2'b10, 16'h006C, -1, -1, -1, 2'b00);
    chk("pre_rst_bit", got_bit, 1);
    run_bit(8, 2'b10, 16'hFFFF, -1, 4, -1, 2'b00);
    chk("rst_seen", rst_seen, 1);
    chk("rst_outs", post_rst, 4'b0000);
    chk("rst_cnt",  vld_cnt,  0);
    run_bit(8, 2'b10, 16'hFFFF, -1, -1, -1, 2'b00);
    chk("post_cnt",   vld_cnt,   1);
    chk("post_edge",  vld_edge,  6);
    chk("post_bit",   got_bit,   1);
    chk("post_noise", got_noise, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
